// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - NREGS x XLEN register file with per-register pending scoreboard
// Optional feature macro: REGFILE_WRITE_BYPASS_EN (same-cycle write-to-read forwarding)
module regfile_scoreboard #(
   parameter int XLEN     = 32,
   parameter int NREGS    = 32,
   parameter int AW       = $clog2(NREGS),
   parameter int ZERO_REG = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   src_one,
   input  logic [AW-1:0]   src_two,
   output logic [XLEN-1:0] out_one,
   output logic [XLEN-1:0] out_two,
   output logic            busy_one,
   output logic            busy_two,
   input  logic [AW-1:0]   dest,
   input  logic            write_enable,
   input  logic [XLEN-1:0] data_in,
   input  logic            reserve_en,
   input  logic [AW-1:0]   reserve_addr,
   input  logic            flush,
   output logic [AW:0]     pending_count
);

   logic [XLEN-1:0]  regs [NREGS];
   logic [NREGS-1:0] pending;
   logic [NREGS-1:0] pending_next;
   logic [AW:0]      count_next;
   logic             write_ok;
   logic             reserve_ok;
   logic             zero_one;
   logic             zero_two;

   // Writes and reserves aimed at the hard-wired zero register are dropped here.
   assign write_ok   = write_enable && !((ZERO_REG != 0) && (dest == '0));
   assign reserve_ok = reserve_en && !((ZERO_REG != 0) && (reserve_addr == '0));
   assign zero_one   = (ZERO_REG != 0) && (src_one == '0);
   assign zero_two   = (ZERO_REG != 0) && (src_two == '0);

   // Next pending vector: flush clears first, a completing write clears its bit,
   // and a reserve is applied last so a new producer always wins.
   always_comb begin
      pending_next = flush ? '0 : pending;
      if (write_ok) begin
         pending_next[dest] = 1'b0;
      end
      if (reserve_ok) begin
         pending_next[reserve_addr] = 1'b1;
      end
   end

   // Population count of the post-update pending vector, registered alongside it.
   always_comb begin
      count_next = '0;
      for (int i = 0; i < NREGS; i++) begin
         count_next = count_next + {{AW{1'b0}}, pending_next[i]};
      end
   end

   // Register array, pending bits and pending count; rst overrides every other request.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
         pending       <= '0;
         pending_count <= '0;
      end else begin
         if (write_ok) begin
            regs[dest] <= data_in;
         end
         pending       <= pending_next;
         pending_count <= count_next;
      end
   end

`ifdef REGFILE_WRITE_BYPASS_EN
   // Read ports with same-cycle forwarding of the write port; a matching reserve keeps busy set.
   always_comb begin
      out_one  = zero_one ? '0 : regs[src_one];
      busy_one = zero_one ? 1'b0 : pending[src_one];
      out_two  = zero_two ? '0 : regs[src_two];
      busy_two = zero_two ? 1'b0 : pending[src_two];
      if (write_ok && (dest == src_one)) begin
         out_one  = data_in;
         busy_one = reserve_ok && (reserve_addr == src_one);
      end
      if (write_ok && (dest == src_two)) begin
         out_two  = data_in;
         busy_two = reserve_ok && (reserve_addr == src_two);
      end
   end
`else
   // Read ports return stored state only; the zero register always reads 0 and idle.
   always_comb begin
      out_one  = zero_one ? '0 : regs[src_one];
      busy_one = zero_one ? 1'b0 : pending[src_one];
      out_two  = zero_two ? '0 : regs[src_two];
      busy_two = zero_two ? 1'b0 : pending[src_two];
   end
`endif

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - randomized self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;
   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int AW    = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   src_one, src_two, dest, reserve_addr;
   logic [XLEN-1:0] out_one, out_two, data_in;
   logic            busy_one, busy_two, write_enable, reserve_en, flush;
   logic [AW:0]     pending_count;

   int errors = 0;
   int checks = 0;

   logic [31:0] m_reg  [NREGS];
   bit          m_pend [NREGS];

   always #5 clk = ~clk;

   regfile_scoreboard #(.XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(1)) dut (
      .clk(clk), .rst(rst),
      .src_one(src_one), .src_two(src_two),
      .out_one(out_one), .out_two(out_two),
      .busy_one(busy_one), .busy_two(busy_two),
      .dest(dest), .write_enable(write_enable), .data_in(data_in),
      .reserve_en(reserve_en), .reserve_addr(reserve_addr),
      .flush(flush), .pending_count(pending_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int m_count();
      int n = 0;
      for (int i = 0; i < NREGS; i++) n += int'(m_pend[i]);
      return n;
   endfunction

   // Expected read-port view of register s in the current cycle.
   task automatic exp_port(input int s, input bit we, input int d, input logic [31:0] din,
                           input bit re, input int ra, output logic [31:0] o, output bit b);
      o = (s == 0) ? 32'h0 : m_reg[s];
      b = (s == 0) ? 1'b0 : m_pend[s];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (we && d == s && s != 0) begin
         o = din;
         b = re && (ra == s);
      end
`endif
   endtask

   // One clock of stimulus: check combinational reads mid-cycle, then the model
   // advances on the edge and the registered pending count is checked.
   task automatic cycle(input bit r, input int s1, input int s2, input bit we, input int d,
                        input logic [31:0] din, input bit re, input int ra, input bit fl);
      logic [31:0] eo;
      bit          eb;
      rst = r; src_one = AW'(s1); src_two = AW'(s2);
      write_enable = we; dest = AW'(d); data_in = din;
      reserve_en = re; reserve_addr = AW'(ra); flush = fl;
      #4;
      exp_port(s1, we, d, din, re, ra, eo, eb);
      check("out_one", out_one, eo);
      check("busy_one", {31'b0, busy_one}, {31'b0, eb});
      exp_port(s2, we, d, din, re, ra, eo, eb);
      check("out_two", out_two, eo);
      check("busy_two", {31'b0, busy_two}, {31'b0, eb});
      @(posedge clk);
      if (r) begin
         for (int i = 0; i < NREGS; i++) begin
            m_reg[i] = 32'h0;
            m_pend[i] = 1'b0;
         end
      end else begin
         if (we && d != 0) m_reg[d] = din;
         for (int i = 1; i < NREGS; i++) begin
            if (re && ra == i)                 m_pend[i] = 1'b1;
            else if ((we && d == i) || fl)     m_pend[i] = 1'b0;
         end
      end
      #1;
      check("pending_count", {26'b0, pending_count}, m_count());
   endtask

   task automatic idle(input int s1, input int s2);
      cycle(0, s1, s2, 0, 0, 32'h0, 0, 0, 0);
   endtask

   initial begin
      rst = 1'b1; src_one = '0; src_two = '0; dest = '0; data_in = '0;
      write_enable = 1'b0; reserve_en = 1'b0; reserve_addr = '0; flush = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         m_reg[i] = 32'h0;
         m_pend[i] = 1'b0;
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("reset_out_one", out_one, 32'h0);
      check("reset_busy_one", {31'b0, busy_one}, 32'h0);
      check("reset_count", {26'b0, pending_count}, 32'h0);

      // basic write/read
      cycle(0, 5, 31, 1, 5, 32'hDEADBEEF, 0, 0, 0);
      cycle(0, 5, 31, 1, 31, 32'h12345678, 0, 0, 0);
      check("rd_reg5", out_one, 32'hDEADBEEF);
      check("rd_reg31", out_two, 32'h12345678);

      // zero register ignores writes and reserves
      cycle(0, 0, 0, 1, 0, 32'hFFFFFFFF, 1, 0, 0);
      check("zero_out", out_one, 32'h0);
      check("zero_busy", {31'b0, busy_one}, 32'h0);
      check("zero_count", {26'b0, pending_count}, 32'h0);

      // scoreboard reserve then complete
      cycle(0, 7, 0, 0, 0, 32'h0, 1, 7, 0);
      check("rsv7_busy", {31'b0, busy_one}, 32'h1);
      check("rsv7_count", {26'b0, pending_count}, 32'h1);
      cycle(0, 7, 0, 1, 7, 32'hA5A5A5A5, 0, 0, 0);
      check("wr7_busy", {31'b0, busy_one}, 32'h0);
      check("wr7_count", {26'b0, pending_count}, 32'h0);
      check("wr7_data", out_one, 32'hA5A5A5A5);

      // write and reserve the same register: reserve wins, data lands
      cycle(0, 9, 9, 1, 9, 32'h99999999, 1, 9, 0);
      check("col9_busy", {31'b0, busy_one}, 32'h1);
      check("col9_data", out_one, 32'h99999999);

      // flush with reserve: only the new reservation survives
      cycle(0, 4, 6, 0, 0, 32'h0, 1, 4, 0);
      cycle(0, 4, 6, 0, 0, 32'h0, 1, 6, 0);
      check("pre_flush_count", {26'b0, pending_count}, 32'h3);
      cycle(0, 3, 4, 0, 0, 32'h0, 1, 3, 1);
      check("flush_count", {26'b0, pending_count}, 32'h1);
      check("flush_busy3", {31'b0, busy_one}, 32'h1);
      check("flush_busy4", {31'b0, busy_two}, 32'h0);

      // same-cycle read of a register being written (old value unless bypassed)
      cycle(0, 0, 12, 1, 12, 32'h11111111, 0, 0, 0);
      cycle(0, 0, 12, 1, 12, 32'h0BADF00D, 0, 0, 0);
      check("rd_reg12", out_two, 32'h0BADF00D);

      // random writes followed by reset; every register must read back 0
      for (int i = 0; i < 20; i++)
         cycle(0, $urandom_range(31), $urandom_range(31), 1, $urandom_range(31), $urandom,
               $urandom_range(1), $urandom_range(31), 0);
      cycle(1, 0, 0, 0, 0, 32'h0, 0, 0, 0);
      for (int i = 0; i < NREGS; i += 2) begin
         idle(i, i + 1);
         check("rst_rd_a", out_one, 32'h0);
         check("rst_rd_b", out_two, 32'h0);
      end

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(49) == 0, $urandom_range(31), $urandom_range(31),
               $urandom_range(1), $urandom_range(31), $urandom,
               $urandom_range(2) != 0, $urandom_range(31), $urandom_range(9) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
